// File: rtl/prog_ms_timer.sv
// Programmable millisecond timeout timer: a prescaler makes 1 ms ticks that drive a
// loadable down-counter with one-shot/periodic modes, pause, restart and abort.
module prog_ms_timer #(
   parameter int unsigned CLK_PER_MS = 50000,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             start,
   input  logic             clear,
   input  logic             periodic,
   input  logic [CNT_W-1:0] timeout_ms,
   output logic             busy,
   output logic             time_out,
   output logic             expired,
   output logic [CNT_W-1:0] remaining_ms
);

   localparam int unsigned PreW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PreW-1:0] PreLast = PreW'(CLK_PER_MS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           stateQ, stateD;
   logic [PreW-1:0]  preQ, preD;
   logic [CNT_W-1:0] remQ, remD;
   logic [CNT_W-1:0] reloadQ, reloadD;
   logic             periodicQ, periodicD;
   logic             timeOutQ, timeOutD;
   logic             expiredQ, expiredD;
   logic             tick;

   assign tick = (preQ == PreLast) && (stateQ == StRun) && enable;

   always_comb begin
      stateD    = stateQ;
      preD      = preQ;
      remD      = remQ;
      reloadD   = reloadQ;
      periodicD = periodicQ;
      timeOutD  = 1'b0;
      expiredD  = expiredQ;
      if (clear) begin
         stateD   = StIdle;
         preD     = '0;
         remD     = '0;
         expiredD = 1'b0;
      end else if (start) begin
         stateD    = StRun;
         preD      = '0;
         remD      = timeout_ms;
         reloadD   = timeout_ms;
         periodicD = periodic;
         expiredD  = 1'b0;
      end else begin
         unique case (stateQ)
            StRun: begin
               if (remQ == '0) begin
                  // Zero timeout: expire once and stop, even in periodic mode.
                  timeOutD = 1'b1;
                  expiredD = 1'b1;
                  stateD   = StDone;
                  preD     = '0;
               end else if (enable) begin
                  preD = (preQ == PreLast) ? '0 : preQ + 1'b1;
                  if (tick) begin
                     if (remQ == CNT_W'(1)) begin
                        timeOutD = 1'b1;
                        expiredD = 1'b1;
                        if (periodicQ) begin
                           remD = reloadQ;
                        end else begin
                           remD   = '0;
                           stateD = StDone;
                           preD   = '0;
                        end
                     end else begin
                        remD = remQ - 1'b1;
                     end
                  end
               end
            end
            default: preD = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ    <= StIdle;
         preQ      <= '0;
         remQ      <= '0;
         reloadQ   <= '0;
         periodicQ <= 1'b0;
         timeOutQ  <= 1'b0;
         expiredQ  <= 1'b0;
      end else begin
         stateQ    <= stateD;
         preQ      <= preD;
         remQ      <= remD;
         reloadQ   <= reloadD;
         periodicQ <= periodicD;
         timeOutQ  <= timeOutD;
         expiredQ  <= expiredD;
      end
   end

   assign busy         = (stateQ == StRun);
   assign time_out     = timeOutQ;
   assign expired      = expiredQ;
   assign remaining_ms = remQ;

endmodule

// File: tb/tb_prog_ms_timer.sv
// Self-checking bench for prog_ms_timer: table of timing scenarios with a pulse
// scoreboard, plus hand sequences for reset/clear/restart corner cases.
module tb_prog_ms_timer;

   localparam int unsigned CPM  = 4;
   localparam int unsigned CW   = 8;

   logic          clk = 1'b0;
   logic          rst, enable, start, clear, periodic;
   logic [CW-1:0] timeout_ms;
   logic          busy, time_out, expired;
   logic [CW-1:0] remaining_ms;

   prog_ms_timer #(.CLK_PER_MS(CPM), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .start        (start),
      .clear        (clear),
      .periodic     (periodic),
      .timeout_ms   (timeout_ms),
      .busy         (busy),
      .time_out     (time_out),
      .expired      (expired),
      .remaining_ms (remaining_ms)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tmo;
      int per;
      int pauseAt;
      int pauseLen;
      int restartAt;
      int restartVal;
      int runLen;
      int p0, p1, p2;      // expected pulse edges, -1 = none
      int chkAt;
      int chkBusy, chkExp, chkRem;
      int endBusy, endExp, endRem;
   } row_t;

   row_t rows[5];
   int   pulseQ[$];
   int   k;
   int   nTests = 0;
   int   nFail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      nTests++;
      if (act != exp) begin
         nFail++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, k, act, exp);
      end
   endtask

   // Advance one edge, sample 1 time unit later, and check time_out against the scoreboard.
   task automatic step();
      int expPulse;
      @(posedge clk);
      #1;
      k++;
      expPulse = (pulseQ.size() > 0 && pulseQ[0] == k) ? 1 : 0;
      chk("time_out", int'(time_out), expPulse);
      if (expPulse == 1) void'(pulseQ.pop_front());
   endtask

   task automatic doReset();
      rst = 1'b1; enable = 1'b1; start = 1'b0; clear = 1'b0;
      periodic = 1'b0; timeout_ms = '0;
      pulseQ.delete();
      k = -100;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic doStart(input int tmo, input int per);
      start = 1'b1; timeout_ms = CW'(tmo); periodic = per[0];
      k = -1;
      step();
      start = 1'b0; timeout_ms = CW'(7); periodic = 1'b0;
   endtask

   task automatic chkOuts(input string tag, input int b, input int e, input int r);
      chk({tag, ".busy"}, int'(busy), b);
      chk({tag, ".expired"}, int'(expired), e);
      chk({tag, ".remaining_ms"}, int'(remaining_ms), r);
   endtask

   initial begin
      //          tmo per pAt pLen rAt rVal run  p0  p1  p2 cAt cB cE cR eB eE eR
      rows[0] = '{5, 0, -1, 0, -1, 0, 120, 20, -1, -1,  4, 1, 0, 4, 0, 1, 0};
      rows[1] = '{3, 1, -1, 0, -1, 0,  40, 12, 24, 36, 36, 1, 1, 3, 1, 1, 2};
      rows[2] = '{5, 0,  6, 7, -1, 0,  40, 27, -1, -1, 12, 1, 0, 4, 0, 1, 0};
      rows[3] = '{5, 0, -1, 0, 10, 2,  40, 18, -1, -1, 10, 1, 0, 2, 0, 1, 0};
      rows[4] = '{0, 1, -1, 0, -1, 0,  20,  1, -1, -1,  1, 0, 1, 0, 0, 1, 0};

      doReset();
      chkOuts("reset", 0, 0, 0);
      chk("reset.time_out", int'(time_out), 0);

      foreach (rows[i]) begin
         string tag;
         tag = $sformatf("row%0d", i);
         doReset();
         if (rows[i].p0 >= 0) pulseQ.push_back(rows[i].p0);
         if (rows[i].p1 >= 0) pulseQ.push_back(rows[i].p1);
         if (rows[i].p2 >= 0) pulseQ.push_back(rows[i].p2);
         doStart(rows[i].tmo, rows[i].per);
         chkOuts({tag, ".start"}, 1, 0, rows[i].tmo);
         for (int e = 1; e <= rows[i].runLen; e++) begin
            enable = !(rows[i].pauseAt >= 0 && e >= rows[i].pauseAt &&
                       e < rows[i].pauseAt + rows[i].pauseLen);
            if (e == rows[i].restartAt) begin
               start = 1'b1; timeout_ms = CW'(rows[i].restartVal);
            end else begin
               start = 1'b0; timeout_ms = CW'(7);
            end
            step();
            if (e == rows[i].chkAt)
               chkOuts({tag, ".mid"}, rows[i].chkBusy, rows[i].chkExp, rows[i].chkRem);
         end
         start = 1'b0; enable = 1'b1;
         chkOuts({tag, ".end"}, rows[i].endBusy, rows[i].endExp, rows[i].endRem);
         chk({tag, ".missedPulses"}, pulseQ.size(), 0);
      end

      // rst, then clear, at edge 9 of a 5 ms run: no pulse ever afterwards.
      for (int m = 0; m < 2; m++) begin
         doReset();
         doStart(5, 0);
         for (int e = 1; e <= 8; e++) step();
         if (m == 0) rst = 1'b1; else clear = 1'b1;
         step();
         rst = 1'b0; clear = 1'b0;
         chkOuts(m == 0 ? "abortRst" : "abortClr", 0, 0, 0);
         for (int e = 0; e < 40; e++) step();
         chk(m == 0 ? "abortRst.busyLater" : "abortClr.busyLater", int'(busy), 0);
      end

      // start and clear together: clear wins, and it also drops a set expired flag.
      doReset();
      pulseQ.push_back(1);
      doStart(0, 0);
      step();
      chk("zeroTmo.expired", int'(expired), 1);
      start = 1'b1; clear = 1'b1; timeout_ms = CW'(5);
      k = -1;
      step();
      start = 1'b0; clear = 1'b0;
      chkOuts("startClear", 0, 0, 0);
      for (int e = 0; e < 30; e++) step();

      // Restart from DONE clears expired and reloads.
      pulseQ.push_back(1);
      doStart(0, 0);
      step();
      chk("done.expired", int'(expired), 1);
      doStart(5, 0);
      chkOuts("restartFromDone", 1, 0, 5);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
